serial_mag_comparator: RTL and testbench
========================================

Name: serial_mag_comparator

Overview:
- Bit-serial N-bit magnitude comparator, the sequential counterpart of the team's 1-bit equality comparator.
- Consumes two operands one bit pair per accepted beat, MSB first, and reports a_gt_b / a_eq_b / a_lt_b once the frame completes.
- Sits behind serial links or shift-register datapaths where parallel operands are unavailable.

Parameters:
- WIDTH, 8, operand width in bits (number of bit pairs per frame); legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse arming a new comparison frame.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  current bit of operand A, MSB first.
- b_bit  input  1  current bit of operand B, MSB first.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse: result flags are valid from this cycle.
- a_gt_b  output  1  A > B.
- a_eq_b  output  1  A == B.
- a_lt_b  output  1  A < B.
- bits_seen  output  CNT_W  number of bit pairs accepted in the current frame.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy, done, a_gt_b, a_eq_b, a_lt_b all 0; bits_seen=0. Reset has priority over all other inputs and aborts any frame in progress with no done pulse.
- States: IDLE, COMPARE, DONE.
- IDLE: bit_valid is ignored. start=1 -> COMPARE at the next edge; busy=1; result flags cleared to 0; bits_seen=0; internal decided flag cleared.
- COMPARE: each cycle with bit_valid=1 accepts one pair and increments bits_seen.
  - While undecided: a_bit>b_bit latches GT and sets decided; a_bit<b_bit latches LT and sets decided; equal bits leave it undecided.
  - Once decided, later bits are still consumed to keep frame alignment but cannot change the verdict.
  - bit_valid=0 holds all state; gaps of any length are legal.
- When the WIDTH-th pair is accepted -> DONE at the next edge.
- DONE (one cycle): done=1; busy=0; exactly one of a_gt_b / a_eq_b / a_lt_b is 1 (EQ if never decided). State -> IDLE.
- Flags hold their value in IDLE until the next start or reset.
- Latency: done asserts exactly one cycle after the edge that accepts the last bit pair. Minimum frame duration is start + WIDTH + 1 cycles.
- start while in COMPARE: restarts the frame. Counter and decided flag are cleared, and bit_valid in that same cycle is ignored.
- start during the DONE cycle: done still pulses, and the new frame arms (state -> COMPARE instead of IDLE).
- The flags are one-hot or all-zero at all times. All-zero occurs only after reset, or after start before the next done.
- bits_seen saturates at WIDTH, and bit_valid in DONE is ignored.

Decomposition:
- Shared package cmp_pkg:
  - state enum {IDLE, COMPARE, DONE};
  - result encoding constants CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10, which are reused by the future parallel comparator wrappers.
- One natural sub-module, serial_bit_cmp_cell. It is a registered 1-bit cell holding the decided flag and the 2-bit verdict, with an update enable and a synchronous clear. The top module keeps only the FSM and the counter.

Test Plan (WIDTH=8):
- Equal operands: start, then A=0x5A, B=0x5A streamed on 8 consecutive valid cycles -> done 1 cycle after the 8th bit, a_eq_b=1, others 0, bits_seen=8.
- Early decision: A=0x80, B=0x7F -> verdict fixed at the first bit, busy stays 1 for all 8 bits, and done pulses once with a_gt_b=1. A=0x00, B=0x01 -> a_lt_b=1, decided only on the last bit.
- Gapped stream: A=0x3C, B=0x3D with bit_valid low for 3 cycles between each bit -> done exactly 1 cycle after the 8th valid bit, a_lt_b=1, with no early done.
- Restart: start, 4 bits of A=0xF0/B=0x0F, then start again, then a full frame of 0x11/0x22 -> a single done pulse with a_lt_b=1 and bits_seen=8.
- Reset mid-frame: rst=1 after 5 bits -> on the next cycle all outputs are 0 and state is IDLE. bit_valid pulses with no start produce no done.
- Back-to-back: start asserted in the DONE cycle of a 0xFF/0xFE frame -> done with a_gt_b=1, then the next frame 0x01/0x01 yields a_eq_b=1 with no idle cycle lost.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared comparator types: FSM states and 2-bit verdict encoding.
// Verdict codes are shared with the parallel comparator wrappers.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_e;

  typedef logic [1:0] cmp_res_t;

  localparam cmp_res_t CMP_EQ = 2'b00;
  localparam cmp_res_t CMP_GT = 2'b01;
  localparam cmp_res_t CMP_LT = 2'b10;

  // Returns {lt, eq, gt}; all zero while no verdict is published.
  function automatic logic [2:0] cmp_flags(
    input logic     valid,
    input cmp_res_t res
  );
    logic [2:0] f;
    f = 3'b000;
    if (valid) begin
      unique case (1'b1)
        (res == CMP_GT): f = 3'b001;
        (res == CMP_LT): f = 3'b100;
        default:         f = 3'b010;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/serial_bit_cmp_cell.sv
// Registered 1-bit magnitude cell: first differing bit pair fixes
// the verdict; later pairs cannot change it until cleared.
module serial_bit_cmp_cell
  import cmp_pkg::*;
(
  input  logic     clk,
  input  logic     clr_i,
  input  logic     en_i,
  input  logic     a_i,
  input  logic     b_i,
  output logic     decided_o,
  output cmp_res_t res_o
);

  logic     decided_q, decided_d;
  cmp_res_t res_q, res_d;

  always_comb begin
    decided_d = decided_q;
    res_d     = res_q;
    if (clr_i) begin
      decided_d = 1'b0;
      res_d     = CMP_EQ;
    end else if (en_i && !decided_q) begin
      unique case (1'b1)
        (a_i && !b_i): begin
          decided_d = 1'b1;
          res_d     = CMP_GT;
        end
        (!a_i && b_i): begin
          decided_d = 1'b1;
          res_d     = CMP_LT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    decided_q <= decided_d;
    res_q     <= res_d;
  end

  assign decided_o = decided_q;
  assign res_o     = res_q;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: frame FSM and bit
// counter around a registered verdict cell.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic [CNT_W-1:0] bits_seen
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic             accept;
  logic             decided;
  cmp_res_t         res;
  logic [2:0]       flags;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPARE;
          cnt_d   = '0;
          rv_d    = 1'b0;
        end
      end
      COMPARE: begin
        if (start) begin
          cnt_d = '0;
          rv_d  = 1'b0;
        end else if (bit_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + ONE;
          if (cnt_q == LAST) begin
            state_d = DONE;
            rv_d    = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = COMPARE;
          cnt_d   = '0;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
    end
  end

  // Start clears the verdict in any state, including the DONE cycle.
  serial_bit_cmp_cell u_cell (
    .clk       (clk),
    .clr_i     (rst | start),
    .en_i      (accept),
    .a_i       (a_bit),
    .b_i       (b_bit),
    .decided_o (decided),
    .res_o     (res)
  );

  assign flags     = cmp_flags(rv_q, res);
  assign a_gt_b    = flags[0];
  assign a_eq_b    = flags[1];
  assign a_lt_b    = flags[2];
  assign busy      = (state_q == COMPARE);
  assign done      = (state_q == DONE);
  assign bits_seen = cnt_q;

  logic unused_decided;
  assign unused_decided = decided;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (WIDTH=8): vector table
// plus restart, reset and back-to-back sequences.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, start, bit_valid, a_bit, b_bit;
  logic             busy, done, a_gt_b, a_eq_b, a_lt_b;
  logic [CNT_W-1:0] bits_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b),
    .a_lt_b    (a_lt_b),
    .bits_seen (bits_seen)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    logic [2:0] exp; // {lt, eq, gt}
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flags();
    return {a_lt_b, a_eq_b, a_gt_b};
  endfunction

  // Streams WIDTH bit pairs MSB first; assumes a freshly armed frame.
  task automatic stream(input logic [7:0] a, input logic [7:0] b,
                        input int gap, input logic [2:0] exp);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      step();
      bit_valid = 1'b0;
      if (i != 0) begin
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 1);
        chk("mid_flags", flags(), 0);
        chk("mid_cnt", bits_seen, 64'(WIDTH - i));
        for (int g = 0; g < gap; g++) begin
          step();
          chk("gap_done", done, 0);
          chk("gap_cnt", bits_seen, 64'(WIDTH - i));
        end
      end
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_flags", flags(), exp);
    chk("end_cnt", bits_seen, 64'(WIDTH));
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_flags", flags(), 0);
    chk("arm_cnt", bits_seen, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h5A, 8'h5A, 0, 3'b010};
    vecs[1] = '{8'h80, 8'h7F, 0, 3'b001};
    vecs[2] = '{8'h00, 8'h01, 0, 3'b100};
    vecs[3] = '{8'h3C, 8'h3D, 3, 3'b100};
    vecs[4] = '{8'hFF, 8'h00, 1, 3'b001};
    vecs[5] = '{8'hA5, 8'hA4, 0, 3'b001};

    rst = 1'b1; start = 1'b0; bit_valid = 1'b0;
    a_bit = 1'b0; b_bit = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_cnt", bits_seen, 0);

    foreach (vecs[k]) begin
      arm();
      stream(vecs[k].a, vecs[k].b, vecs[k].gap, vecs[k].exp);
      bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_hold", flags(), vecs[k].exp);
      chk("post_cnt", bits_seen, 64'(WIDTH));
      step();
    end

    // Restart mid-frame; bit_valid alongside start is ignored.
    arm();
    for (int i = 7; i >= 4; i--) begin
      bit_valid = 1'b1;
      a_bit = 1'(8'hF0 >> i);
      b_bit = 1'(8'h0F >> i);
      step();
      chk("rs_done", done, 0);
    end
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    step();
    start = 1'b0; bit_valid = 1'b0;
    chk("rs_cnt", bits_seen, 0);
    chk("rs_busy", busy, 1);
    chk("rs_flags", flags(), 0);
    stream(8'h11, 8'h22, 0, 3'b100);
    step();

    // Reset mid-frame aborts with no done pulse.
    arm();
    for (int i = 7; i >= 3; i--) begin
      bit_valid = 1'b1;
      a_bit = 1'(8'hC3 >> i);
      b_bit = 1'(8'h3C >> i);
      step();
    end
    chk("pre_rst_cnt", bits_seen, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_flags", flags(), 0);
    chk("mr_cnt", bits_seen, 0);
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1;
      a_bit = 1'(i);
      b_bit = 1'b0;
      step();
      chk("nostart_done", done, 0);
      chk("nostart_busy", busy, 0);
      chk("nostart_cnt", bits_seen, 0);
    end
    bit_valid = 1'b0;

    // Start in the DONE cycle arms the next frame immediately.
    arm();
    stream(8'hFF, 8'hFE, 0, 3'b001);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    chk("b2b_flags", flags(), 0);
    chk("b2b_cnt", bits_seen, 0);
    stream(8'h01, 8'h01, 0, 3'b010);
    step();
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
